// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter onto one memory bus with address decode and error detection.
// Grant and bus drive are combinational in the request cycle; the response follows exactly one cycle later, fully pipelined.
module mem_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IMEM_BASE  = 'h0000_0000,
    parameter int                    IMEM_AW    = 12,
    parameter logic [ADDR_WIDTH-1:0] SRAM_BASE  = 'h0000_1000,
    parameter int                    SRAM_AW    = 12,
    parameter logic [ADDR_WIDTH-1:0] SW_ADDR    = 'h0000_2000,
    parameter logic [ADDR_WIDTH-1:0] LED_ADDR   = 'h0000_2004,
    parameter logic [ADDR_WIDTH-1:0] SSEG_ADDR  = 'h0000_2008,
    localparam int                   DATA_BYTES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic                  i_err,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_BYTES-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic                  d_err,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  m_en,
    output logic                  m_we,
    output logic [DATA_BYTES-1:0] m_be,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [4:0]            m_sel,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    // Offset-from-base wraps for addresses below base, so one shift test covers both bounds.
    function automatic logic in_region(input logic [ADDR_WIDTH-1:0] a,
                                       input logic [ADDR_WIDTH-1:0] base,
                                       input int aw);
        return ((a - base) >> aw) == '0;
    endfunction

    logic                  r_last_d;
    logic                  r_vld;
    logic                  r_own_d;
    logic                  r_err;
    logic                  r_we;

    logic                  w_gnt_i;
    logic                  w_gnt_d;
    logic                  w_any;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_we;
    logic [DATA_BYTES-1:0] w_be;
    logic [4:0]            w_sel;
    logic                  w_err;
    logic                  w_go;
    logic                  w_rvld;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_gnt_d = ~rst & d_req & (~i_req | ~r_last_d);
    assign w_gnt_i = ~rst & i_req & ~w_gnt_d;
    assign w_any   = w_gnt_i | w_gnt_d;

    assign w_addr  = w_gnt_d ? d_addr : i_addr;
    assign w_we    = w_gnt_d & d_we;
    assign w_be    = w_gnt_d ? d_be : '1;

    assign w_sel[0] = in_region(w_addr, IMEM_BASE, IMEM_AW);
    assign w_sel[1] = in_region(w_addr, SRAM_BASE, SRAM_AW);
    assign w_sel[2] = (w_addr == SW_ADDR);
    assign w_sel[3] = (w_addr == LED_ADDR);
    assign w_sel[4] = (w_addr == SSEG_ADDR);

    assign w_err = (w_sel == 5'd0)
                 | (w_addr[1:0] != 2'b00)
                 | (w_gnt_i & ~w_sel[0])
                 | (w_we & w_sel[2])
                 | (w_we & (d_be == '0));
    assign w_go  = w_any & ~w_err;

    assign i_gnt   = w_gnt_i;
    assign d_gnt   = w_gnt_d;
    assign m_en    = w_go;
    assign m_sel   = w_go ? w_sel : 5'd0;
    assign m_we    = w_go & w_we;
    assign m_be    = w_go ? w_be : '0;
    assign m_addr  = w_go ? w_addr : '0;
    assign m_wdata = (w_go & w_gnt_d) ? d_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b0;
            r_vld    <= 1'b0;
            r_own_d  <= 1'b0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            r_vld <= w_any;
            if (w_any) begin
                r_last_d <= w_gnt_d;
                r_own_d  <= w_gnt_d;
                r_err    <= w_err;
                r_we     <= w_we;
            end
        end
    end

    // Gating with rst drops a response whose grant happened just before reset.
    assign w_rvld  = r_vld & ~rst;
    assign w_rdata = (r_err | r_we) ? '0 : m_rdata;

    assign i_rvalid = w_rvld & ~r_own_d;
    assign i_err    = i_rvalid & r_err;
    assign i_rdata  = i_rvalid ? w_rdata : '0;
    assign d_rvalid = w_rvld & r_own_d;
    assign d_err    = d_rvalid & r_err;
    assign d_rdata  = d_rvalid ? w_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        m_en, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic [4:0]  m_sel;
    logic [31:0] m_rdata = '0;

    int checks = 0;
    int errors = 0;

    // Reference model state: who won last, and the one outstanding response.
    bit last_was_d = 1'b0;
    bit pend       = 1'b0;
    bit pend_d     = 1'b0;
    bit pend_err   = 1'b0;
    bit pend_we    = 1'b0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_sel(m_sel), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Region index: 0 IMEM, 1 SRAM, 2 SW, 3 LED, 4 SSEG, -1 unmapped.
    function automatic int region(input logic [31:0] a);
        if (a < 32'h1000)       return 0;
        if (a < 32'h2000)       return 1;
        if (a == 32'h2000)      return 2;
        if (a == 32'h2004)      return 3;
        if (a == 32'h2008)      return 4;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0: return 32'($urandom_range(0, 1023)) << 2;
            1: return 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
            2: return 32'h2000;
            3: return 32'h2004;
            4: return 32'h2008;
            5: return 32'h1000 + 32'($urandom_range(0, 4095));
            6: return 32'h3000 + (32'($urandom_range(0, 255)) << 2);
            default: return $urandom();
        endcase
    endfunction

    task automatic step(input bit rs, input bit ir, input logic [31:0] ia,
                        input bit dr, input bit dw, input logic [3:0] db,
                        input logic [31:0] da, input logic [31:0] dwd,
                        input logic [31:0] mr);
        bit          g_i, g_d, gwe, gerr, en;
        logic [31:0] ga;
        logic [3:0]  gbe;
        logic [4:0]  esel;
        int          rg;
        bit          resp;
        @(negedge clk);
        rst = rs; i_req = ir; i_addr = ia;
        d_req = dr; d_we = dw; d_be = db; d_addr = da; d_wdata = dwd; m_rdata = mr;
        #1;
        resp = !rs && pend;
        chk("i_rvalid", i_rvalid, resp && !pend_d);
        chk("i_err",    i_err,    resp && !pend_d && pend_err);
        chk("i_rdata",  i_rdata,  (resp && !pend_d && !pend_err) ? mr : 32'd0);
        chk("d_rvalid", d_rvalid, resp && pend_d);
        chk("d_err",    d_err,    resp && pend_d && pend_err);
        chk("d_rdata",  d_rdata,  (resp && pend_d && !pend_err && !pend_we) ? mr : 32'd0);

        g_i = 1'b0; g_d = 1'b0;
        if (!rs) begin
            if (ir && dr) begin
                if (last_was_d) g_i = 1'b1;
                else            g_d = 1'b1;
            end else begin
                g_i = ir;
                g_d = dr;
            end
        end
        if (g_d) begin ga = da; gwe = dw;   gbe = db;    end
        else     begin ga = ia; gwe = 1'b0; gbe = 4'hF;  end
        rg   = region(ga);
        gerr = (rg < 0) || (ga % 4 != 0) || (g_i && rg != 0)
            || (gwe && rg == 2) || (gwe && gbe == 4'h0);
        en   = (g_i || g_d) && !gerr;
        esel = en ? 5'(1 << rg) : 5'd0;

        chk("i_gnt", i_gnt, g_i);
        chk("d_gnt", d_gnt, g_d);
        chk("m_en",  m_en,  en);
        chk("m_sel", m_sel, esel);
        chk("m_we",  m_we,  en && gwe);
        chk("m_be",  m_be,  en ? gbe : 4'h0);
        if (en || rs) chk("m_addr", m_addr, en ? ga : 32'd0);
        if (g_d || !en) chk("m_wdata", m_wdata, en ? dwd : 32'd0);

        if (rs) begin
            pend = 1'b0;
            last_was_d = 1'b0;
        end else begin
            pend = g_i || g_d;
            if (pend) begin
                pend_d     = g_d;
                pend_err   = gerr;
                pend_we    = gwe;
                last_was_d = g_d;
            end
        end
    endtask

    initial begin
        // Reset with live requests: they must be ignored.
        step(1, 1, 32'h10, 1, 1, 4'hF, 32'h2004, 32'h5, 32'h1234);
        step(1, 0, 32'h0,  0, 0, 4'h0, 32'h0,    32'h0, 32'h0);
        // Both requesting for four cycles: D, I, D, I.
        for (int k = 0; k < 4; k++)
            step(0, 1, 32'h10, 1, 0, 4'hF, 32'h1004, 32'h0, 32'h1111_0000 + 32'(k));
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'hCAFE_F00D);
        // Fetch from IMEM, data arrives the following cycle.
        step(0, 1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        step(0, 0, 32'h0,  0, 0, 4'h0, 32'h0, 32'h0, 32'hDEAD_BEEF);
        // LED write.
        step(0, 0, 32'h0, 1, 1, 4'hF, 32'h2004, 32'hA5, 32'h0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0,    32'h0,  32'h7777_7777);
        // Error cases back to back.
        step(0, 0, 32'h0,    1, 1, 4'hF, 32'h2000, 32'h1, 32'h0);
        step(0, 0, 32'h0,    1, 0, 4'hF, 32'h1002, 32'h0, 32'h9999_9999);
        step(0, 1, 32'h1000, 0, 0, 4'h0, 32'h0,    32'h0, 32'h8888_8888);
        step(0, 0, 32'h0,    1, 0, 4'hF, 32'h3000, 32'h0, 32'h6666_6666);
        step(0, 0, 32'h0,    1, 1, 4'h0, 32'h1000, 32'h2, 32'h5555_5555);
        step(0, 0, 32'h0,    0, 0, 4'h0, 32'h0,    32'h0, 32'h4444_4444);
        // Grant a read, then reset before its response.
        step(0, 0, 32'h0, 1, 0, 4'hF, 32'h1000, 32'h0, 32'h0);
        step(1, 1, 32'h4, 1, 0, 4'hF, 32'h1000, 32'h0, 32'hABCD_0123);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0,    32'h0, 32'hABCD_0123);
        step(0, 1, 32'h8, 1, 0, 4'hF, 32'h1008, 32'h0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0,    32'h0, 32'h1357_9BDF);
        // Randomized traffic with occasional reset.
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 60) == 0, 1'($urandom_range(0, 1)), rand_addr(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 rand_addr(), $urandom(), $urandom());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning bus data width; DATA_BYTES = DATA_WIDTH/8.
REQ-003 SHALL have parameters IMEM_BASE 0x0000_0000 / IMEM_AW 12, SRAM_BASE 0x0000_1000 / SRAM_AW 12, SW_ADDR 0x0000_2000, LED_ADDR 0x0000_2004, SSEG_ADDR 0x0000_2008, meaning the region map.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 i_req / i_addr  in  1 / ADDR_WIDTH  instruction-fetch request and byte address.
REQ-007 i_gnt / i_rvalid / i_err / i_rdata  out  1 / 1 / 1 / DATA_WIDTH  fetch grant, response valid, response error, fetched word.
REQ-008 d_req / d_we / d_be / d_addr / d_wdata  in  1 / 1 / DATA_BYTES / ADDR_WIDTH / DATA_WIDTH  data-port request, write enable, byte enables, address, write data.
REQ-009 d_gnt / d_rvalid / d_err / d_rdata  out  1 / 1 / 1 / DATA_WIDTH  data-port grant, response valid, error, read data.
REQ-010 m_en / m_we / m_be / m_addr / m_wdata  out  1 / 1 / DATA_BYTES / ADDR_WIDTH / DATA_WIDTH  shared memory-bus strobe, write, byte enables, address, write data.
REQ-011 m_sel  out  5  one-hot region select: bit0 IMEM, bit1 SRAM, bit2 SW, bit3 LED, bit4 SSEG.
REQ-012 m_rdata  in  DATA_WIDTH  read data, valid the cycle after m_en.

Function
REQ-013 Requester SHALL hold req and attributes stable until its gnt; gnt is combinational in the request cycle.
REQ-014 At most one grant per cycle; i_gnt and d_gnt SHALL never both be 1.
REQ-015 Single requester: granted the same cycle.
REQ-016 Both requesting: round-robin via last_grant register; grant the port not granted last; last_grant updates on every grant.
REQ-017 Decode: IMEM if addr in [IMEM_BASE, IMEM_BASE+2^IMEM_AW); SRAM if in [SRAM_BASE, SRAM_BASE+2^SRAM_AW); SW/LED/SSEG on exact word match.
REQ-018 Error conditions: unmapped address; addr[1:0] != 0; fetch outside IMEM; write to SW; d_be == 0 on a write.
REQ-019 Granted legal access SHALL drive m_en=1, m_sel, m_addr=request addr, m_we/m_be/m_wdata (data port; fetch drives m_we=0, m_be all ones) in the grant cycle.
REQ-020 Granted erroneous access SHALL drive m_en=0, m_sel=0; error flag is registered.
REQ-021 When m_en=0, m_we, m_be, m_wdata and m_sel SHALL be 0.
REQ-022 Response latency exactly 1 cycle: cycle after a grant, the owning port's rvalid=1 for one cycle; owner, error flag and we are registered at grant.
REQ-023 Response data: read OK -> rdata=m_rdata, err=0; write OK -> rdata=0, err=0; error -> rdata=0, err=1.
REQ-024 Non-owning port's rvalid/err/rdata SHALL be 0.
REQ-025 Fully pipelined: a new grant may occur in the same cycle as the previous response; back-to-back grants give 1 access per cycle.

Reset
REQ-026 In a cycle with rst=1, gnt, m_en, m_we, m_be, m_sel, m_addr, m_wdata SHALL be 0; requests are ignored.
REQ-027 After reset, i_rvalid, d_rvalid, i_err, d_err, rdata outputs SHALL be 0; pending response cleared; last_grant = I (first tie goes to D).
REQ-028 Reset mid-operation: a grant made in the cycle before rst=1 produces no rvalid.

Verification
REQ-029 Reset, then d_req and i_req both held 4 cycles, legal addrs -> grants D,I,D,I; rvalid one cycle after each grant to matching port.
REQ-030 i_req addr 0x0000_0010, m_rdata=0xDEAD_BEEF next cycle -> m_sel=00001, m_en=1; then i_rvalid=1, i_rdata=0xDEAD_BEEF, i_err=0.
REQ-031 d write addr 0x0000_2004, be 0xF, wdata 0x0000_00A5 -> m_sel=01000, m_we=1; next cycle d_rvalid=1, d_err=0, d_rdata=0.
REQ-032 Errors: d write to 0x0000_2000; d read 0x0000_1002; i fetch 0x0000_1000; d read 0x0000_3000 -> m_en=0 each; next cycle rvalid=1, err=1, rdata=0.
REQ-033 Grant d read of 0x0000_1000, assert rst next cycle -> d_rvalid=0 that cycle and after; all outputs 0 during reset.
